// File: rtl/maxicore32_pkg.sv
// maxicore32_pkg: shared types for the maxicore32 core.
//   opcode, ALU op, branch condition, access size and FSM state enums,
//   instruction field bit positions and a 16->32 sign-extension helper.
package maxicore32_pkg;

  typedef enum logic [5:0] {
    OP_NOP       = 6'h00,
    OP_HALT      = 6'h01,
    OP_LOADI     = 6'h02,
    OP_LOADUPPER = 6'h03,
    OP_ALU       = 6'h04,
    OP_LOAD      = 6'h05,
    OP_STORE     = 6'h06,
    OP_BRANCH    = 6'h07
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOT = 4'd5, ALU_LSL = 4'd6, ALU_LSR = 4'd7,
    ALU_ASR = 4'd8, ALU_CPY = 4'd9, ALU_CMP = 4'd10, ALU_MUL = 4'd11
  } aluop_e;

  typedef enum logic [3:0] {
    COND_AL = 4'd0, COND_EQ = 4'd1, COND_NE = 4'd2, COND_CS = 4'd3,
    COND_CC = 4'd4, COND_MI = 4'd5, COND_PL = 4'd6
  } cond_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10, SIZE_BAD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_STOPPED
  } state_e;

  localparam int OP_MSB    = 31, OP_LSB    = 26;
  localparam int RD_MSB    = 25, RD_LSB    = 22;
  localparam int RS1_MSB   = 21, RS1_LSB   = 18;
  localparam int RS2_MSB   = 17, RS2_LSB   = 14;
  localparam int SIZE_MSB  = 17, SIZE_LSB  = 16;
  localparam int IMM_MSB   = 15, IMM_LSB   = 0;
  localparam int ALUOP_MSB = 3,  ALUOP_LSB = 0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/maxicore32_alu.sv
// maxicore32_alu: combinational ALU.
//   aluop_i, a_i, b_i : operation and operands
//   result_o, z_o, n_o, c_o : result and flags (C = carry / borrow)
//   illegal_o : aluop outside the supported set;  write_o : result goes to rd
// MAXICORE32_MUL_EN enables op 11 (MUL, low 32 bits).
module maxicore32_alu
  import maxicore32_pkg::*;
(
  input  logic [3:0]  aluop_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        z_o,
  output logic        n_o,
  output logic        c_o,
  output logic        illegal_o,
  output logic        write_o
);
  logic [32:0] sum;

  always_comb begin
    result_o  = '0;
    c_o       = 1'b0;
    illegal_o = 1'b0;
    write_o   = 1'b1;
    sum       = '0;
    case (aluop_e'(aluop_i))
      ALU_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[31:0];
        c_o      = sum[32];
      end
      // bit 32 of the 33-bit difference is the borrow (a < b unsigned)
      ALU_SUB, ALU_CMP: begin
        sum      = {1'b0, a_i} - {1'b0, b_i};
        result_o = sum[31:0];
        c_o      = sum[32];
        write_o  = (aluop_i != ALU_CMP);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_NOT: result_o = ~a_i;
      ALU_LSL: result_o = a_i << b_i[4:0];
      ALU_LSR: result_o = a_i >> b_i[4:0];
      ALU_ASR: result_o = $signed(a_i) >>> b_i[4:0];
      ALU_CPY: result_o = a_i;
`ifdef MAXICORE32_MUL_EN
      ALU_MUL: result_o = a_i * b_i;
`endif
      default: begin
        illegal_o = 1'b1;
        write_o   = 1'b0;
      end
    endcase
    z_o = (result_o == 32'h0);
    n_o = result_o[31];
  end
endmodule

// File: rtl/maxicore32_program_counter.sv
// maxicore32_program_counter: program counter register.
//   clock, reset : clock, async active-high reset (loads RESET_PC)
//   inc_i        : advance by one word
//   load_i       : load target_i (branch), wins over inc_i
//   pc_o         : current byte address
module maxicore32_program_counter #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);
  logic [31:0] program_counter;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       program_counter <= RESET_PC;
    else if (load_i) program_counter <= target_i;
    else if (inc_i)  program_counter <= program_counter + 32'd4;
  end

  assign pc_o = program_counter;
endmodule

// File: rtl/maxicore32_register_file.sv
// maxicore32_register_file: 16 x 32 general registers, cleared on reset.
//   ra_i/ra_o, rb_i/rb_o : two combinational read ports
//   we_i, wa_i, wd_i     : one write port, written at the clock edge
module maxicore32_register_file (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  ra_i,
  input  logic [3:0]  rb_i,
  input  logic        we_i,
  input  logic [3:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] ra_o,
  output logic [31:0] rb_o
);
  logic [31:0] register_file [0:15];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) register_file[i] <= '0;
    end else if (we_i) begin
      register_file[wa_i] <= wd_i;
    end
  end

  assign ra_o = register_file[ra_i];
  assign rb_o = register_file[rb_i];
endmodule

// File: rtl/maxicore32.sv
// maxicore32: 32-bit multi-cycle load/store core, 16 registers, one
// word-addressed bus (address[31:24] 0x00 = RAM, 0xFF = peripherals).
//   clock, reset         : clock, async active-high reset
//   address              : word address (byte address [31:2])
//   data_in              : read data, one cycle after the read cycle
//   data_out, data_strobes : write data / big-endian byte-lane enables
//   read, write          : bus cycle qualifiers (combinational from state)
//   bus_error, halted    : sticky stop reasons
// Build option: MAXICORE32_MUL_EN adds ALU op 11 (MUL).
//
// state        | meaning
// ST_FETCH     | read instruction at PC
// ST_DECODE    | latch IR, PC += 4
// ST_EXECUTE   | ALU / LOADI / branch; load/store address check
// ST_MEMORY    | one data bus cycle
// ST_WRITEBACK | load data into rd
// ST_STOPPED   | halted or bus error, bus idle until reset
module maxicore32
  import maxicore32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [29:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  data_strobes,
  output logic        read,
  output logic        write,
  output logic        bus_error,
  output logic        halted
);
  state_e      state_q;
  logic [31:0] ir_q;
  logic        z_q, n_q, c_q, bus_error_q, halted_q;

  opcode_e     op;
  logic [3:0]  rd, rs1, rs2, aluop;
  logic [1:0]  size;
  logic [31:0] imm_sext, pc, rs1_data, rb_data, ea;
  logic [31:0] alu_result, store_data, load_data, rf_wd;
  logic        alu_z, alu_n, alu_c, alu_illegal, alu_write;
  logic        rf_we, take, pc_load, misaligned, size_bad, fetch_act, mem_act;
  logic [3:0]  mem_strobes;

  assign op       = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign rd       = ir_q[RD_MSB:RD_LSB];
  assign rs1      = ir_q[RS1_MSB:RS1_LSB];
  assign rs2      = ir_q[RS2_MSB:RS2_LSB];
  assign size     = ir_q[SIZE_MSB:SIZE_LSB];
  assign aluop    = ir_q[ALUOP_MSB:ALUOP_LSB];
  assign imm_sext = sext16(ir_q[IMM_MSB:IMM_LSB]);
  assign ea       = rs1_data + imm_sext;

  // Second read port serves rs2 for ALU ops, otherwise rd (store data, LOADUPPER).
  maxicore32_register_file register_file (
    .clock(clock), .reset(reset), .ra_i(rs1), .rb_i((op == OP_ALU) ? rs2 : rd),
    .we_i(rf_we), .wa_i(rd), .wd_i(rf_wd), .ra_o(rs1_data), .rb_o(rb_data)
  );

  maxicore32_program_counter #(.RESET_PC(RESET_PC)) program_counter (
    .clock(clock), .reset(reset), .inc_i(state_q == ST_DECODE), .load_i(pc_load),
    .target_i(pc + (imm_sext << 2)), .pc_o(pc)
  );

  maxicore32_alu alu (
    .aluop_i(aluop), .a_i(rs1_data), .b_i(rb_data), .result_o(alu_result),
    .z_o(alu_z), .n_o(alu_n), .c_o(alu_c), .illegal_o(alu_illegal), .write_o(alu_write)
  );

  always_comb begin
    case (cond_e'(rd))
      COND_AL: take = 1'b1;
      COND_EQ: take = z_q;
      COND_NE: take = ~z_q;
      COND_CS: take = c_q;
      COND_CC: take = ~c_q;
      COND_MI: take = n_q;
      COND_PL: take = ~n_q;
      default: take = 1'b0;
    endcase
  end
  assign pc_load = (state_q == ST_EXECUTE) && (op == OP_BRANCH) && take;

  always_comb begin
    mem_strobes = 4'b0000;
    misaligned  = 1'b0;
    size_bad    = 1'b0;
    store_data  = rb_data;
    load_data   = data_in;
    case (size_e'(size))
      SIZE_BYTE: begin
        mem_strobes = 4'b1000 >> ea[1:0];
        store_data  = {4{rb_data[7:0]}};
        load_data   = {24'h0, data_in[{~ea[1:0], 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        mem_strobes = ea[1] ? 4'b0011 : 4'b1100;
        misaligned  = ea[0];
        store_data  = {2{rb_data[15:0]}};
        load_data   = {16'h0, ea[1] ? data_in[15:0] : data_in[31:16]};
      end
      SIZE_WORD: begin
        mem_strobes = 4'b1111;
        misaligned  = (ea[1:0] != 2'b00);
      end
      default: size_bad = 1'b1;
    endcase
  end

  // Gated by reset so an access in flight is dropped the instant reset rises.
  assign fetch_act    = !reset && (state_q == ST_FETCH) && (pc[1:0] == 2'b00);
  assign mem_act      = !reset && (state_q == ST_MEMORY);
  assign read         = fetch_act || (mem_act && op == OP_LOAD);
  assign write        = mem_act && (op == OP_STORE);
  assign address      = (state_q == ST_MEMORY) ? ea[31:2] : pc[31:2];
  assign data_strobes = fetch_act ? 4'b1111 : (mem_act ? mem_strobes : 4'b0000);
  assign data_out     = write ? store_data : 32'h0;
  assign bus_error    = bus_error_q;
  assign halted       = halted_q;

  always_comb begin
    rf_we = 1'b0;
    rf_wd = '0;
    if (state_q == ST_EXECUTE) begin
      case (op)
        OP_LOADI:     begin rf_we = 1'b1; rf_wd = imm_sext; end
        OP_LOADUPPER: begin rf_we = 1'b1; rf_wd = {ir_q[IMM_MSB:IMM_LSB], rb_data[15:0]}; end
        OP_ALU:       begin rf_we = alu_write; rf_wd = alu_result; end
        default:      ;
      endcase
    end else if (state_q == ST_WRITEBACK && op == OP_LOAD) begin
      rf_we = 1'b1;
      rf_wd = load_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      ir_q        <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      bus_error_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (pc[1:0] != 2'b00) begin
            bus_error_q <= 1'b1;
            state_q     <= ST_STOPPED;
          end else begin
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          ir_q    <= data_in;
          state_q <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          state_q <= ST_FETCH;
          case (op)
            OP_NOP, OP_LOADI, OP_LOADUPPER, OP_BRANCH: ;
            OP_ALU: begin
              if (alu_illegal) begin
                halted_q <= 1'b1;
                state_q  <= ST_STOPPED;
              end else begin
                z_q <= alu_z;
                n_q <= alu_n;
                c_q <= alu_c;
              end
            end
            OP_LOAD, OP_STORE: begin
              if (size_bad) begin
                halted_q <= 1'b1;
                state_q  <= ST_STOPPED;
              end else if (misaligned) begin
                bus_error_q <= 1'b1;
                state_q     <= ST_STOPPED;
              end else begin
                state_q <= ST_MEMORY;
              end
            end
            default: begin
              halted_q <= 1'b1;
              state_q  <= ST_STOPPED;
            end
          endcase
        end
        ST_MEMORY:    state_q <= ST_WRITEBACK;
        ST_WRITEBACK: state_q <= ST_FETCH;
        default:      state_q <= ST_STOPPED;
      endcase
    end
  end
endmodule

// File: tb/tb_maxicore32.sv
module tb_maxicore32;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] address;
  logic [31:0] data_in, data_out;
  logic [3:0]  data_strobes;
  logic        read, write, bus_error, halted;

  maxicore32 #(.RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in),
    .data_out(data_out), .data_strobes(data_strobes), .read(read), .write(write),
    .bus_error(bus_error), .halted(halted)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // memory model: RAM window 0x00, registered read data
  logic [31:0] ram  [0:255];
  logic [31:0] prog [0:255];
  logic        load_req = 1'b0;
  logic [31:0] rdata;
  assign data_in = rdata;

  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) ram[i] <= prog[i];
    end else if (write && address[29:22] == 8'h00) begin
      for (int b = 0; b < 4; b++)
        if (data_strobes[b]) ram[address[7:0]][b*8 +: 8] <= data_out[b*8 +: 8];
    end
    if (read) rdata <= (address[29:22] == 8'h00) ? ram[address[7:0]] : 32'h0;
  end

  // write scoreboard
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;
  wr_t sb[$];
  wr_t exp_wr;
  int  n_reads = 0, n_writes = 0, n_sub_fetch = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (read) n_reads++;
      if (read && address == 30'd28) n_sub_fetch++;
      if (write) begin
        n_writes++;
        if (sb.size() > 0) exp_wr = sb.pop_front();
        else exp_wr = '1;
        chk("bus_wr", {30'h0, address, data_out, data_strobes}, {30'h0, exp_wr});
      end
    end
  end

  task automatic exp_write(input logic [31:0] byte_addr, input logic [31:0] d, input logic [3:0] s);
    sb.push_back({byte_addr[31:2], d, s});
  endtask

  function automatic logic [31:0] e_imm(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 2'b00, imm};
  endfunction
  function automatic logic [31:0] e_mem(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [1:0] sz,
                                        input logic [15:0] imm);
    return {op, rd, rs1, sz, imm};
  endfunction
  function automatic logic [31:0] e_alu(input logic [3:0] aop, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {6'h04, rd, rs1, rs2, 10'h0, aop};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic hold_and_load();
    reset    = 1'b1;
    load_req = 1'b1;
    @(posedge clock);
    #1 load_req = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic wait_stop(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while (!(halted || bus_error) && cyc < budget) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk(tag, cyc < budget, 1);
  endtask

  int r0, w0;

  initial begin
    // ---------------- run 1: main program ----------------
    clear_prog();
    prog[0]  = e_imm(6'h02, 4'd1, 4'd0, 16'd5);          // LOADI r1,5
    prog[1]  = e_imm(6'h02, 4'd2, 4'd0, 16'hFFFD);       // LOADI r2,-3
    prog[2]  = e_alu(4'd0, 4'd3, 4'd1, 4'd2);            // ADD r3=r1+r2
    prog[3]  = e_imm(6'h07, 4'd3, 4'd0, 16'd1);          // BRANCH CS +1
    prog[4]  = e_mem(6'h06, 4'd0, 4'd0, 2'b10, 16'h0);   // skipped store
    prog[5]  = e_imm(6'h07, 4'd2, 4'd0, 16'd1);          // BRANCH NE +1
    prog[6]  = e_mem(6'h06, 4'd0, 4'd0, 2'b10, 16'h0);   // skipped store
    prog[7]  = e_imm(6'h03, 4'd4, 4'd0, 16'hFF00);       // LOADUPPER r4
    prog[8]  = e_mem(6'h06, 4'd3, 4'd4, 2'b10, 16'h10);  // STORE w r3
    prog[9]  = e_imm(6'h02, 4'd5, 4'd0, 16'h00AB);       // LOADI r5,0xAB
    prog[10] = e_imm(6'h02, 4'd6, 4'd0, 16'h0041);       // LOADI r6,0x41
    prog[11] = e_mem(6'h06, 4'd5, 4'd6, 2'b00, 16'h0);   // STORE b r5 -> 0x41
    prog[12] = e_mem(6'h05, 4'd7, 4'd6, 2'b00, 16'h0);   // LOAD b r7 <- 0x41
    prog[13] = e_mem(6'h06, 4'd7, 4'd4, 2'b10, 16'h14);  // STORE w r7
    prog[14] = e_imm(6'h07, 4'd0, 4'd0, 16'd9);          // BRANCH AL -> 24
    prog[24] = e_mem(6'h05, 4'd8, 4'd6, 2'b01, 16'hFFFF);// LOAD h r8 <- 0x40
    prog[25] = e_mem(6'h06, 4'd8, 4'd4, 2'b01, 16'h1A);  // STORE h r8
    prog[26] = e_imm(6'h02, 4'd1, 4'd0, 16'd3);          // LOADI r1,3
    prog[27] = e_imm(6'h02, 4'd2, 4'd0, 16'd1);          // LOADI r2,1
    prog[28] = e_alu(4'd1, 4'd1, 4'd1, 4'd2);            // SUB r1=r1-r2
    prog[29] = e_imm(6'h07, 4'd2, 4'd0, 16'hFFFE);       // BRANCH NE -2
    prog[30] = e_mem(6'h06, 4'd1, 4'd4, 2'b10, 16'h20);  // STORE w r1
    prog[31] = e_imm(6'h02, 4'd9, 4'd0, 16'h8000);       // LOADI r9
    prog[32] = e_alu(4'd8, 4'd10, 4'd9, 4'd2);           // ASR r10
    prog[33] = e_alu(4'd7, 4'd11, 4'd9, 4'd2);           // LSR r11
    prog[34] = e_mem(6'h06, 4'd10, 4'd4, 2'b10, 16'h24);
    prog[35] = e_mem(6'h06, 4'd11, 4'd4, 2'b10, 16'h28);
    prog[36] = e_alu(4'd3, 4'd12, 4'd9, 4'd5);           // OR r12
    prog[37] = e_mem(6'h06, 4'd12, 4'd4, 2'b10, 16'h2C);
    prog[38] = e_imm(6'h01, 4'd0, 4'd0, 16'h0);          // HALT

    exp_write(32'hFF000010, 32'h00000002, 4'b1111);
    exp_write(32'h00000041, 32'hABABABAB, 4'b0100);
    exp_write(32'hFF000014, 32'h000000AB, 4'b1111);
    exp_write(32'hFF00001A, 32'h00AB00AB, 4'b0011);
    exp_write(32'hFF000020, 32'h00000000, 4'b1111);
    exp_write(32'hFF000024, 32'hFFFFC000, 4'b1111);
    exp_write(32'hFF000028, 32'h7FFFC000, 4'b1111);
    exp_write(32'hFF00002C, 32'hFFFF80AB, 4'b1111);

    hold_and_load();
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_strobes", data_strobes, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_halted", halted, 0);

    r0 = n_sub_fetch;
    release_reset();
    #1;
    chk("fetch0_addr", address, 0);
    chk("fetch0_read", read, 1);
    chk("fetch0_strobes", data_strobes, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 chk("early_no_write", write, 0);
    end

    wait_stop("run1_done", 2000);
    chk("run1_halted", halted, 1);
    chk("run1_bus_error", bus_error, 0);
    chk("run1_pc", dut.program_counter.program_counter, 32'd39 * 4);
    chk("loop_iters", n_sub_fetch - r0, 3);
    chk("run1_sb_empty", sb.size(), 0);
    r0 = n_reads;
    w0 = n_writes;
    repeat (10) @(posedge clock);
    #1 chk("halt_frozen", (n_reads - r0) + (n_writes - w0), 0);

    // ---------------- run 2: misaligned word load ----------------
    clear_prog();
    prog[0] = e_imm(6'h02, 4'd1, 4'd0, 16'h0042);        // LOADI r1,0x42
    prog[1] = e_mem(6'h05, 4'd2, 4'd1, 2'b10, 16'h0);    // LOAD w -> error
    prog[2] = e_mem(6'h06, 4'd2, 4'd1, 2'b10, 16'h0);    // never reached
    hold_and_load();
    r0 = n_reads;
    w0 = n_writes;
    release_reset();
    wait_stop("run2_done", 200);
    chk("err_bus_error", bus_error, 1);
    chk("err_halted", halted, 0);
    repeat (10) @(posedge clock);
    #1;
    chk("err_reads", n_reads - r0, 2);
    chk("err_writes", n_writes - w0, 0);
    chk("err_read_low", read, 0);
    chk("err_pc", dut.program_counter.program_counter, 32'd8);

    // ---------------- run 3: registers cleared, illegal ALU op ----------------
    clear_prog();
    prog[0] = e_mem(6'h06, 4'd3, 4'd0, 2'b10, 16'h0080); // STORE r3 (0 after reset)
    prog[1] = e_alu(4'd15, 4'd1, 4'd1, 4'd1);            // illegal ALU op
    prog[2] = e_mem(6'h06, 4'd1, 4'd0, 2'b10, 16'h0084); // never reached
    exp_write(32'h00000080, 32'h0, 4'b1111);
    hold_and_load();
    release_reset();
    wait_stop("run3_done", 200);
    chk("ill_halted", halted, 1);
    chk("ill_bus_error", bus_error, 0);
    repeat (5) @(posedge clock);
    #1;
    chk("ill_pc", dut.program_counter.program_counter, 32'd8);
    chk("run3_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
